// File: rtl/alu_seq.sv
// Handshaked 16-function ALU with valid/ready on both sides and a multi-cycle restoring divider.
// Define ALU_DIV_EN to build the divider; without it, opcode 0011 completes at once with ERR=1.
module alu_seq #(
  parameter int OPRND_WIDTH = 8,
  parameter int OUT_WIDTH   = 2 * OPRND_WIDTH,
  parameter int CTRL_WIDTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [OPRND_WIDTH-1:0] A,
  input  logic [OPRND_WIDTH-1:0] B,
  input  logic [CTRL_WIDTH-1:0]  ALU_FUN,
  output logic [OUT_WIDTH-1:0]   ALU_OUT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   ERR
);

  localparam int W = OPRND_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL  = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_DIV  = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_NAND = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_NOR  = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_NOP  = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_EQ   = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_GT   = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] OP_LT   = CTRL_WIDTH'(11);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(12);
  localparam logic [CTRL_WIDTH-1:0] OP_SLA  = CTRL_WIDTH'(13);
  localparam logic [CTRL_WIDTH-1:0] OP_SRB  = CTRL_WIDTH'(14);
  localparam logic [CTRL_WIDTH-1:0] OP_SLB  = CTRL_WIDTH'(15);

  logic [1:0]           state_q, state_d;
  logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
  logic                 err_q, err_d;
  logic [OUT_WIDTH-1:0] a_ext, b_ext, op_res;
  logic                 op_err, op_div;
  logic                 accept;

  assign IN_READY  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (state_q == ST_DONE);
  assign ALU_OUT   = alu_out_q;
  assign ERR       = err_q;

  // Single-cycle result of the presented opcode; op_div flags a divide that needs iteration.
  always_comb begin
    a_ext  = OUT_WIDTH'(A);
    b_ext  = OUT_WIDTH'(B);
    op_res = '0;
    op_err = 1'b0;
    op_div = 1'b0;
    case (ALU_FUN)
      OP_ADD:  op_res = a_ext + b_ext;
      OP_SUB:  op_res = a_ext - b_ext;
      OP_MUL:  op_res = a_ext * b_ext;
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (B == '0) begin
          op_res = '1;
          op_err = 1'b1;
        end else begin
          op_div = 1'b1;
        end
`else
        op_err = 1'b1;
`endif
      end
      OP_AND:  op_res = a_ext & b_ext;
      OP_OR:   op_res = a_ext | b_ext;
      OP_NAND: op_res = ~(a_ext & b_ext);
      OP_NOR:  op_res = ~(a_ext | b_ext);
      OP_NOP:  op_res = '0;
      OP_EQ:   op_res = (A == B) ? OUT_WIDTH'(1) : '0;
      OP_GT:   op_res = (A > B) ? OUT_WIDTH'(2) : '0;
      OP_LT:   op_res = (A < B) ? OUT_WIDTH'(3) : '0;
      OP_SRA:  op_res = a_ext >> 1;
      OP_SLA:  op_res = a_ext << 1;
      OP_SRB:  op_res = b_ext >> 1;
      OP_SLB:  op_res = b_ext << 1;
      default: op_res = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  localparam int         CNT_W   = $clog2(W) + 1;
  localparam logic [1:0] ST_BUSY = 2'd1;

  logic [W-1:0]     dvsr_q, quo_q, rem_q;
  logic [W-1:0]     quo_n, rem_n;
  logic [W:0]       shifted, trial;
  logic [CNT_W-1:0] cnt_q;
  logic             div_last;

  // One restoring step: shift in the next dividend bit, subtract, keep only if non-negative.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[W]) begin
      rem_n = trial[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_n = shifted[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b0};
    end
  end

  assign div_last = (cnt_q == CNT_W'(W - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dvsr_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (accept && op_div) begin
      dvsr_q <= B;
      quo_q  <= A;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == ST_BUSY) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d   = ST_DONE;
          alu_out_d = op_res;
          err_d     = op_err;
`ifdef ALU_DIV_EN
          if (op_div) begin
            state_d   = ST_BUSY;
            alu_out_d = alu_out_q;
            err_d     = err_q;
          end
`endif
        end else if ((state_q == ST_DONE) && OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_DIV_EN
      ST_BUSY: begin
        // The final step's result goes straight into ALU_OUT.
        if (div_last) begin
          state_d   = ST_DONE;
          alu_out_d = OUT_WIDTH'({rem_n, quo_n});
          err_d     = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      err_q     <= err_d;
    end
  end

endmodule
